mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared memory of the multi-cycle CPU. The instruction-fetch port and the load/store port each issue a request. The block arbitrates round-robin, latches the winning command, and drives one transaction to a variable-latency memory that answers with an ack. It then returns a one-cycle done pulse with read data to the winner. The block sits between the control FSM/datapath and the unified instruction/data memory.

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter that sequences one variable-latency
// memory transaction at a time and returns a done pulse with read data to the winner.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          m_en,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          grant,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic last, last_n, grant_n, m_en_n, m_we_n, if_done_n, d_done_n, err_n;
    logic [3:0] m_be_n;
    logic [AW-1:0] m_addr_n;
    logic [DW-1:0] m_wdata_n, if_rdata_n, d_rdata_n;
    logic [7:0] cnt, cnt_n;
    logic go, win, fin;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b0;
            grant    <= 1'b0;
            cnt      <= '0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_be     <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            grant    <= grant_n;
            cnt      <= cnt_n;
            m_en     <= m_en_n;
            m_we     <= m_we_n;
            m_be     <= m_be_n;
            m_addr   <= m_addr_n;
            m_wdata  <= m_wdata_n;
            if_done  <= if_done_n;
            d_done   <= d_done_n;
            if_rdata <= if_rdata_n;
            d_rdata  <= d_rdata_n;
            err      <= err_n;
        end
    end

    always_comb begin
        fin = state == BUSY && (m_ack || cnt == 8'(TIMEOUT - 1));
        // in DONE the requester just served still holds req, so only the other one may win
        go = state == IDLE ? (if_req || d_req) : (state == DONE && (grant ? if_req : d_req));
        win = state == IDLE ? (d_req && (!if_req || !last)) : !grant;
        state_n    = state;
        last_n     = last;
        grant_n    = grant;
        cnt_n      = state == BUSY ? cnt + 8'd1 : cnt;
        m_en_n     = m_en;
        m_we_n     = m_we;
        m_be_n     = m_be;
        m_addr_n   = m_addr;
        m_wdata_n  = m_wdata;
        if_done_n  = 1'b0;
        d_done_n   = 1'b0;
        if_rdata_n = if_rdata;
        d_rdata_n  = d_rdata;
        err_n      = 1'b0;
        if (fin) begin
            state_n   = DONE;
            m_en_n    = 1'b0;
            m_we_n    = 1'b0;
            m_be_n    = '0;
            if_done_n = !grant;
            d_done_n  = grant;
            err_n     = !m_ack;
            if (grant) d_rdata_n = m_ack ? m_rdata : '0;
            else if_rdata_n = m_ack ? m_rdata : '0;
        end else if (go) begin
            state_n   = BUSY;
            last_n    = win;
            grant_n   = win;
            cnt_n     = '0;
            m_en_n    = 1'b1;
            m_we_n    = win && d_we;
            m_be_n    = win ? d_be : 4'hF;
            m_addr_n  = win ? d_addr : if_addr;
            m_wdata_n = win ? d_wdata : '0;
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; expected dones and memory commands are queued
// by the stimulus and checked by independent monitors.
module tb_mem_arbiter;
    logic clk = 0, rst = 1;
    logic if_req = 0, d_req = 0, d_we = 0;
    logic [3:0] d_be = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic if_done, d_done, m_en, m_we, grant, err, m_ack;
    logic [3:0] m_be;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic port; logic [31:0] data; logic err; } exp_t;
    typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; logic b2b; int len; } cmd_t;
    exp_t exp_q[$];
    cmd_t cmd_q[$];
    int n_chk = 0, n_pass = 0;
    int ack_delay = 3, bcnt = 0;
    logic stray = 0, keep = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return a == 32'h40 ? 32'h2008_0005 : a ^ 32'hC0DE_0000;
    endfunction

    // memory model: ack in the ack_delay-th BUSY cycle (0 = never), plus an optional stray ack
    assign m_ack = (m_en && ack_delay != 0 && bcnt == ack_delay) || stray;
    assign m_rdata = m_ack ? rd(m_addr) : 32'hBAD0_BAD0;
    always @(negedge clk) bcnt = m_en ? bcnt + 1 : 0;

    always @(negedge clk) begin
        exp_t e;
        if (if_done || d_done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 160'({if_done, d_done}), 160'(0));
            else begin
                e = exp_q.pop_front();
                chk("done", 160'({d_done, if_done, grant, err, d_done ? d_rdata : if_rdata}),
                    160'({e.port, !e.port, e.port, e.err, e.data}));
            end
        end
    end

    int cyc = 0, fall = -10, blen = 0;
    logic pen = 0;
    cmd_t cur;
    always @(negedge clk) begin
        cyc++;
        if (m_en && !pen) begin
            blen = 1;
            if (cmd_q.size() == 0) chk("unexpected_cmd", 160'(m_addr), 160'(0));
            else begin
                cur = cmd_q.pop_front();
                chk("cmd", 160'({m_we, m_be, m_addr, m_wdata, cyc - fall == 1}),
                    160'({cur.we, cur.be, cur.addr, cur.wdata, cur.b2b}));
            end
        end else if (m_en) begin
            blen++;
            chk("hold", 160'({m_we, m_be, m_addr, m_wdata}), 160'({cur.we, cur.be, cur.addr, cur.wdata}));
        end else if (pen) begin
            fall = cyc;
            chk("len", 160'({blen, m_we, m_be}), 160'({cur.len, 1'b0, 4'b0}));
        end
        pen = m_en;
    end

    task automatic step();
        @(negedge clk);
        if (if_done && !keep) if_req = 0;
        if (d_done && !keep) d_req = 0;
    endtask

    task automatic push_e(input logic p, input logic [31:0] d, input logic e);
        exp_q.push_back('{p, d, e});
    endtask

    task automatic push_c(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] w,
                          input logic b, input int len);
        cmd_q.push_back('{we, be, a, w, b, len});
    endtask

    task automatic reset_dut();
        rst = 1;
        repeat (2) step();
        rst = 0;
        step();
    endtask

    task automatic wait_idle();
        logic ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            step();
            ok = exp_q.size() == 0 && cmd_q.size() == 0 && !m_en && !pen;
        end
        chk("idle_wait", 160'(ok), 160'(1));
        repeat (2) step();
    endtask

    function automatic logic [159:0] outs();
        return 160'({m_en, m_we, m_be, grant, err, if_done, d_done, m_addr, m_wdata, if_rdata, d_rdata});
    endfunction

    initial begin
        int n;
        reset_dut();
        chk("reset_values", outs(), 160'(0));
        // single fetch, ack in the 3rd BUSY cycle
        ack_delay = 3;
        push_c(0, 4'hF, 32'h40, 0, 0, 3);
        push_e(0, 32'h2008_0005, 0);
        if_addr = 32'h40; if_req = 1;
        wait_idle();
        // simultaneous requests after reset: data wins, fetch follows with no gap
        reset_dut();
        ack_delay = 1;
        push_c(1, 4'h3, 32'h100, 32'hDEAD_BEEF, 0, 1);
        push_c(0, 4'hF, 32'h44, 0, 1, 1);
        push_e(1, 32'hC0DE_0100, 0);
        push_e(0, 32'hC0DE_0044, 0);
        d_we = 1; d_be = 4'h3; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; if_addr = 32'h44;
        d_req = 1; if_req = 1;
        wait_idle();
        // both held: strict alternation D,F,D,F,D,F
        ack_delay = 2; keep = 1;
        d_we = 0; d_be = 4'hF; d_addr = 32'h208; d_wdata = 0; if_addr = 32'h80;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin push_c(0, 4'hF, 32'h208, 0, i != 0, 2); push_e(1, 32'hC0DE_0208, 0); end
            else begin push_c(0, 4'hF, 32'h80, 0, 1, 2); push_e(0, 32'hC0DE_0080, 0); end
        end
        d_req = 1; if_req = 1; n = 0;
        for (int c = 0; c < 200 && n < 6; c++) begin
            step();
            if (if_done || d_done) n++;
        end
        if_req = 0; d_req = 0; keep = 0;
        chk("alt_done_count", 160'(n), 160'(6));
        wait_idle();
        // timeout: no ack for 16 BUSY cycles
        ack_delay = 0;
        push_c(0, 4'hF, 32'h300, 0, 0, 16);
        push_e(1, 32'h0, 1);
        d_addr = 32'h300; d_req = 1;
        wait_idle();
        // ack arrives on the last permitted cycle: ack wins
        ack_delay = 16;
        push_c(0, 4'hF, 32'h304, 0, 0, 16);
        push_e(1, 32'hC0DE_0304, 0);
        d_addr = 32'h304; d_req = 1;
        wait_idle();
        // reset in the 2nd BUSY cycle of a fetch, stray ack afterwards
        ack_delay = 5;
        push_c(0, 4'hF, 32'h48, 0, 0, 2);
        if_addr = 32'h48; if_req = 1;
        repeat (2) step();
        rst = 1; if_req = 0;
        step();
        rst = 0;
        chk("mid_reset_values", outs(), 160'(0));
        step();
        stray = 1;
        step();
        stray = 0;
        repeat (2) step();
        chk("stray_ack_ignored", outs(), 160'(0));
        // inputs change after grant: latched command unaffected
        ack_delay = 3;
        push_c(0, 4'hF, 32'h200, 32'h1111_2222, 0, 3);
        push_e(1, 32'hC0DE_0200, 0);
        d_addr = 32'h200; d_wdata = 32'h1111_2222; d_req = 1;
        step();
        d_addr = 32'h300; d_req = 0;
        wait_idle();
        chk("exp_queue_drained", 160'(exp_q.size()), 160'(0));
        chk("cmd_queue_drained", 160'(cmd_q.size()), 160'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
